// File: rtl/cvxif_copro_pkg.sv
// Shared types for the CV-X-IF custom-0 coprocessor: opcode, op encoding,
// buffer entry layout and the instruction decoder.
package cvxif_copro_pkg;

  localparam int unsigned COPRO_XLEN = 32;
  localparam int unsigned COPRO_ID_W = 4;

  localparam logic [6:0] OPCODE_CUSTOM0 = 7'b0001011;

  // Encoding equals funct3[1:0] of the accepted instructions.
  typedef enum logic [1:0] {
    OP_ADD  = 2'd0,
    OP_XOR  = 2'd1,
    OP_MIN  = 2'd2,
    OP_MINU = 2'd3
  } copro_op_e;

  typedef struct packed {
    logic [COPRO_ID_W-1:0] id;
    logic [4:0]            rd;
    copro_op_e             op;
    logic [COPRO_XLEN-1:0] rs1;
    logic [COPRO_XLEN-1:0] rs2;
    logic                  committed;
    logic                  killed;
  } copro_entry_t;

  typedef struct packed {
    logic      accept;
    logic [4:0] rd;
    copro_op_e op;
  } copro_decode_t;

  function automatic copro_decode_t copro_decode(input logic [31:0] instr);
    copro_decode_t dec;
    dec.accept = (instr[6:0] == OPCODE_CUSTOM0) &&
                 (instr[31:25] == 7'd0) &&
                 (instr[14] == 1'b0);
    dec.rd     = instr[11:7];
    dec.op     = copro_op_e'(instr[13:12]);
    return dec;
  endfunction

endpackage

// File: rtl/cvxif_copro_alu.sv
// Combinational datapath of the coprocessor: one op applied to two operands.
module cvxif_copro_alu
  import cvxif_copro_pkg::*;
#(
  parameter int unsigned XLEN = COPRO_XLEN
) (
  input  copro_op_e         op,
  input  logic [XLEN-1:0]   rs1,
  input  logic [XLEN-1:0]   rs2,
  output logic [XLEN-1:0]   result
);

  always_comb begin
    result = '0;
    case (op)
      OP_ADD:  result = rs1 + rs2;
      OP_XOR:  result = rs1 ^ rs2;
      OP_MIN:  result = ($signed(rs1) < $signed(rs2)) ? rs1 : rs2;
      OP_MINU: result = (rs1 < rs2) ? rs1 : rs2;
      default: result = '0;
    endcase
  end

endmodule

// File: rtl/cvxif_copro_responder.sv
// Responder side of CV-X-IF: decodes custom-0 instructions, holds them in issue
// order until commit/kill, and returns committed results through a registered port.
module cvxif_copro_responder
  import cvxif_copro_pkg::*;
#(
  parameter int unsigned XLEN    = COPRO_XLEN,
  parameter int unsigned IdWidth = COPRO_ID_W,
  parameter int unsigned Depth   = 4
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               issue_valid_i,
  output logic               issue_ready_o,
  input  logic [31:0]        issue_instr_i,
  input  logic [IdWidth-1:0] issue_id_i,
  input  logic [XLEN-1:0]    issue_rs1_i,
  input  logic [XLEN-1:0]    issue_rs2_i,
  output logic               issue_accept_o,
  output logic               issue_writeback_o,
  input  logic               commit_valid_i,
  input  logic [IdWidth-1:0] commit_id_i,
  input  logic               commit_kill_i,
  output logic               result_valid_o,
  input  logic               result_ready_i,
  output logic [IdWidth-1:0] result_id_o,
  output logic [4:0]         result_rd_o,
  output logic [XLEN-1:0]    result_data_o,
  output logic               result_we_o
);

  localparam int unsigned IdxW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam logic [IdxW:0] PtrOne = {{IdxW{1'b0}}, 1'b1};

  copro_entry_t       entries [Depth];
  logic [Depth-1:0]   entry_valid;
  logic [IdxW:0]      head_ptr;
  logic [IdxW:0]      tail_ptr;
  logic [IdxW-1:0]    head_idx;
  logic [IdxW-1:0]    tail_idx;

  copro_decode_t      dec;
  copro_entry_t       new_entry;
  copro_entry_t       head_entry;
  logic               head_valid;
  logic               full;
  logic               push;
  logic               pop_kill;
  logic               load;
  logic               pop;
  logic [Depth-1:0]   commit_hit;
  logic [XLEN-1:0]    alu_result;

  logic               res_valid;
  logic [IdWidth-1:0] res_id;
  logic [4:0]         res_rd;
  logic [XLEN-1:0]    res_data;

  // Register-source fields are not needed: operands arrive as values.
  logic [9:0]         unused_instr;
  assign unused_instr = issue_instr_i[24:15];

  assign head_idx = head_ptr[IdxW-1:0];
  assign tail_idx = tail_ptr[IdxW-1:0];

  assign dec               = copro_decode(issue_instr_i);
  assign issue_accept_o    = dec.accept;
  assign issue_writeback_o = dec.accept;

  // Full comes only from registered pointers, so a same-cycle pop never frees a slot early.
  assign full          = (head_idx == tail_idx) && (head_ptr[IdxW] != tail_ptr[IdxW]);
  assign issue_ready_o = !full;
  assign push          = issue_valid_i && issue_ready_o && dec.accept;

  always_comb begin
    new_entry           = '0;
    new_entry.id        = issue_id_i;
    new_entry.rd        = dec.rd;
    new_entry.op        = dec.op;
    new_entry.rs1       = issue_rs1_i;
    new_entry.rs2       = issue_rs2_i;
    new_entry.committed = 1'b0;
    new_entry.killed    = 1'b0;
  end

  // Only still-unresolved entries can match, so repeated or stale messages are dropped.
  always_comb begin
    commit_hit = '0;
    for (int i = 0; i < Depth; i++) begin
      commit_hit[i] = commit_valid_i && entry_valid[i] &&
                      !entries[i].committed && !entries[i].killed &&
                      (entries[i].id == commit_id_i);
    end
  end

  assign head_entry = entries[head_idx];
  assign head_valid = entry_valid[head_idx];

  assign pop_kill = head_valid && head_entry.killed;
  assign load     = head_valid && head_entry.committed &&
                    (!res_valid || result_ready_i);
  assign pop      = pop_kill || load;

  cvxif_copro_alu #(
    .XLEN (XLEN)
  ) u_alu (
    .op     (head_entry.op),
    .rs1    (head_entry.rs1),
    .rs2    (head_entry.rs2),
    .result (alu_result)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < Depth; i++) begin
        entries[i] <= '0;
      end
      entry_valid <= '0;
      head_ptr    <= '0;
      tail_ptr    <= '0;
    end else begin
      for (int i = 0; i < Depth; i++) begin
        if (commit_hit[i]) begin
          if (commit_kill_i) begin
            entries[i].killed <= 1'b1;
          end else begin
            entries[i].committed <= 1'b1;
          end
        end
      end
      if (push) begin
        entries[tail_idx]     <= new_entry;
        entry_valid[tail_idx] <= 1'b1;
        tail_ptr              <= tail_ptr + PtrOne;
      end
      if (pop) begin
        entry_valid[head_idx] <= 1'b0;
        head_ptr              <= head_ptr + PtrOne;
      end
    end
  end

  // A load and a drain in the same cycle simply replace the held result.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      res_valid <= 1'b0;
      res_id    <= '0;
      res_rd    <= '0;
      res_data  <= '0;
    end else if (load) begin
      res_valid <= 1'b1;
      res_id    <= head_entry.id;
      res_rd    <= head_entry.rd;
      res_data  <= alu_result;
    end else if (res_valid && result_ready_i) begin
      res_valid <= 1'b0;
    end
  end

  assign result_valid_o = res_valid;
  assign result_we_o    = res_valid;
  assign result_id_o    = res_id;
  assign result_rd_o    = res_rd;
  assign result_data_o  = res_data;

endmodule
